// File: rtl/shift_4bit.sv
// Shift unit: combinational shift-by-one taps plus a registered variable-amount
// shifter (logical/arithmetic/rotate). Rotate is built only with SHIFT_4BIT_ROTATE_EN.
module shift_4bit #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] l_shift,
    output logic [WIDTH-1:0] r_shift,
    input  logic             in_valid,
    input  logic [AMT_W-1:0] amt,
    input  logic [1:0]       mode,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_left,
    output logic [WIDTH-1:0] q_right,
    output logic             q_carry_l,
    output logic             q_carry_r,
    output logic [7:0]       op_count
);

    localparam logic [1:0] MODE_ARITH  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;

    assign l_shift = a << 1;
    assign r_shift = a >> 1;

    logic signed [WIDTH-1:0] a_s;
    logic [WIDTH-1:0]        left_d, right_d;
    logic [WIDTH-1:0]        cl_vec, cr_vec;
    logic                    carry_l_d, carry_r_d;
    int                      amt_int;

    logic             vld_q;
    logic [WIDTH-1:0] left_q, right_q;
    logic             carry_l_q, carry_r_q;
    logic [7:0]       cnt_q;

    always_comb begin
        amt_int   = int'(amt);
        a_s       = $signed(a);
        left_d    = a << amt;
        right_d   = a >> amt;
        cl_vec    = '0;
        cr_vec    = '0;
        carry_l_d = 1'b0;
        carry_r_d = 1'b0;

        if (mode == MODE_ARITH) begin
            right_d = a_s >>> amt;
        end
`ifdef SHIFT_4BIT_ROTATE_EN
        if (mode == MODE_ROTATE) begin
            left_d  = (a << amt) | (a >> (WIDTH - amt_int));
            right_d = (a >> amt) | (a << (WIDTH - amt_int));
        end
`endif
        // Carries are the last bits pushed past each end; rotate wraps the same bits.
        if (amt_int != 0) begin
            cl_vec    = a >> (WIDTH - amt_int);
            cr_vec    = a >> (amt_int - 1);
            carry_l_d = cl_vec[0];
            carry_r_d = cr_vec[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q     <= 1'b0;
            left_q    <= '0;
            right_q   <= '0;
            carry_l_q <= 1'b0;
            carry_r_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                left_q    <= left_d;
                right_q   <= right_d;
                carry_l_q <= carry_l_d;
                carry_r_q <= carry_r_d;
                cnt_q     <= cnt_q + 8'd1;
            end
        end
    end

    assign q_valid   = vld_q;
    assign q_left    = left_q;
    assign q_right   = right_q;
    assign q_carry_l = carry_l_q;
    assign q_carry_r = carry_r_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_shift_4bit.sv
// Scoreboard bench for shift_4bit: stimulus pushes expected results, a negedge
// monitor pops and compares whenever q_valid is presented.
module tb_shift_4bit;

`ifdef SHIFT_4BIT_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] left;
        logic [3:0] right;
        logic       cl;
        logic       cr;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] l_shift, r_shift;
    logic       in_valid;
    logic [1:0] amt;
    logic [1:0] mode;
    logic       q_valid;
    logic [3:0] q_left, q_right;
    logic       q_carry_l, q_carry_r;
    logic [7:0] op_count;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t last_e;
    logic [7:0] exp_cnt = 8'd0;

    shift_4bit dut (
        .clk(clk), .rst_n(rst_n), .a(a), .l_shift(l_shift), .r_shift(r_shift),
        .in_valid(in_valid), .amt(amt), .mode(mode), .q_valid(q_valid),
        .q_left(q_left), .q_right(q_right), .q_carry_l(q_carry_l),
        .q_carry_r(q_carry_r), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] av, input logic [1:0] am, input logic [1:0] md);
        exp_t e;
        int   n;
        bit   rot;
        n   = int'(am);
        rot = (md == 2'b10) && ROT;
        e   = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= n) e.left[i] = av[i-n];
            else        e.left[i] = rot ? av[i-n+4] : 1'b0;
            if (i + n < 4)       e.right[i] = av[i+n];
            else if (rot)        e.right[i] = av[i+n-4];
            else if (md == 2'b01) e.right[i] = av[3];
            else                 e.right[i] = 1'b0;
        end
        e.cl = (n == 0) ? 1'b0 : av[4-n];
        e.cr = (n == 0) ? 1'b0 : av[n-1];
        return e;
    endfunction

    // Issue one request; expected result is enqueued at the edge that accepts it.
    task automatic req(input logic [3:0] av, input logic [1:0] am, input logic [1:0] md,
                       input exp_t e_in);
        exp_t e;
        a = av; amt = am; mode = md; in_valid = 1'b1;
        @(posedge clk);
        exp_cnt = exp_cnt + 8'd1;
        e       = e_in;
        e.cnt   = exp_cnt;
        sb.push_back(e);
        last_e  = e;
        #1;
    endtask

    function automatic exp_t mk(input logic [3:0] l, input logic [3:0] r, input logic cl, input logic cr);
        exp_t e;
        e = '0;
        e.left = l; e.right = r; e.cl = cl; e.cr = cr;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (q_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_q_valid", 32'(q_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("q_left",    32'(q_left),    32'(e.left));
                    chk("q_right",   32'(q_right),   32'(e.right));
                    chk("q_carry_l", 32'(q_carry_l), 32'(e.cl));
                    chk("q_carry_r", 32'(q_carry_r), 32'(e.cr));
                    chk("op_count",  32'(op_count),  32'(e.cnt));
                end
            end else if (sb.size() != 0) begin
                chk("missing_q_valid", 32'(q_valid), 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; a = 4'b0110; amt = 2'd1; mode = 2'b00;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_l_shift", 32'(l_shift), 32'b1100);
            chk("rst_r_shift", 32'(r_shift), 32'b0011);
        end
        chk("rst_q_valid",   32'(q_valid),   32'd0);
        chk("rst_q_left",    32'(q_left),    32'd0);
        chk("rst_q_right",   32'(q_right),   32'd0);
        chk("rst_q_carry_l", 32'(q_carry_l), 32'd0);
        chk("rst_q_carry_r", 32'(q_carry_r), 32'd0);
        chk("rst_op_count",  32'(op_count),  32'd0);
        rst_n = 1'b1; in_valid = 1'b0;

        a = 4'b0010; #1; chk("comb_l_0010", 32'(l_shift), 32'b0100); chk("comb_r_0010", 32'(r_shift), 32'b0001);
        a = 4'b1000; #1; chk("comb_l_1000", 32'(l_shift), 32'b0000); chk("comb_r_1000", 32'(r_shift), 32'b0100);
        a = 4'b1111; #1; chk("comb_l_1111", 32'(l_shift), 32'b1110); chk("comb_r_1111", 32'(r_shift), 32'b0111);
        a = 4'b1001; #1; chk("comb_l_1001", 32'(l_shift), 32'b0010); chk("comb_r_1001", 32'(r_shift), 32'b0100);
        @(posedge clk); #1;
        chk("idle_q_valid", 32'(q_valid), 32'd0);

        req(4'b1011, 2'd2, 2'b00, mk(4'b1100, 4'b0010, 1'b0, 1'b1));
        req(4'b1000, 2'd3, 2'b01, mk(4'b0000, 4'b1111, 1'b0, 1'b0));
        req(4'b0100, 2'd3, 2'b01, mk(4'b0000, 4'b0000, 1'b0, 1'b1));
        if (ROT) req(4'b1001, 2'd1, 2'b10, mk(4'b0011, 4'b1100, 1'b1, 1'b1));
        else     req(4'b1001, 2'd1, 2'b10, mk(4'b0010, 4'b0100, 1'b1, 1'b1));
        req(4'b1010, 2'd0, 2'b01, mk(4'b1010, 4'b1010, 1'b0, 1'b0));
        req(4'b0110, 2'd1, 2'b11, mk(4'b1100, 4'b0011, 1'b0, 1'b0));

        for (int i = 0; i < 250; i++) begin
            logic [7:0] v;
            logic [3:0] av;
            v  = 8'(i);
            av = v[7:4] ^ v[3:0];
            req(av, v[1:0], v[3:2], model(av, v[1:0], v[3:2]));
        end
        in_valid = 1'b0;
        a = 4'b0101; amt = 2'd1; mode = 2'b00;

        repeat (3) begin
            @(posedge clk); #1;
            chk("hold_q_valid",   32'(q_valid),   32'd0);
            chk("hold_q_left",    32'(q_left),    32'(last_e.left));
            chk("hold_q_right",   32'(q_right),   32'(last_e.right));
            chk("hold_q_carry_l", 32'(q_carry_l), 32'(last_e.cl));
            chk("hold_q_carry_r", 32'(q_carry_r), 32'(last_e.cr));
            chk("hold_op_count",  32'(op_count),  32'd0);
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_4bit.md
# shift_4bit

Bit-shift unit that presents single-position logical left and right shifts of an operand combinationally. It also provides a clocked, variable-amount shift path with logical, arithmetic and optional rotate modes, carry-out flags and an operation counter. It sits as a leaf datapath helper that feeds ALU/result muxes, and its combinational outputs can be used directly as shift-by-one taps.

## Interface
- WIDTH, 4, operand width; must be ≥ 2.
- AMT_W, 2, shift-amount width; equals clog2(WIDTH).

- clk  input  1  rising-edge clock for the registered path
- rst_n  input  1  synchronous, active-low reset
- a  input  WIDTH  operand
- l_shift  output  WIDTH  combinational a << 1, zero fill
- r_shift  output  WIDTH  combinational a >> 1, logical, zero fill
- in_valid  input  1  request a registered shift of a this cycle
- amt  input  AMT_W  shift amount, 0..WIDTH-1
- mode  input  2  00 logical, 01 arithmetic right, 10 rotate, 11 reserved (treated as logical)
- q_valid  output  1  registered result valid, one-cycle pulse per accepted request
- q_left  output  WIDTH  registered left result
- q_right  output  WIDTH  registered right result
- q_carry_l  output  1  last bit shifted out of the MSB side
- q_carry_r  output  1  last bit shifted out of the LSB side
- op_count  output  8  count of accepted requests, wraps modulo 256

## Operation
- l_shift and r_shift are pure combinational functions of a. They do not depend on clk, rst_n or any other input.
- A request is accepted when in_valid=1 at a rising edge with rst_n=1.
- Logical mode (00 and 11):
  - q_left = a << amt, zero fill.
  - q_right = a >> amt, zero fill.
- Arithmetic mode (01):
  - q_left is the same as logical left.
  - q_right fills vacated upper bits with a[WIDTH-1].
- Rotate mode (10):
  - Requires ROTATE; see Configuration.
  - q_left = rotate-left of a by amt.
  - q_right = rotate-right of a by amt.
- Carries:
  - When amt=0, both carries are 0 in every mode.
  - Otherwise q_carry_l = a[WIDTH-amt] and q_carry_r = a[amt-1].
  - In rotate mode the carries are the bits that wrapped around, which gives the same indices.
- amt=0 in any mode gives q_left = q_right = a.
- op_count increments by 1 per accepted request. 255 wraps to 0.

## Timing
- Combinational path: l_shift and r_shift settle within the same cycle that a changes. There is no latency.
- Registered path latency is 1 cycle. Inputs sampled at edge N appear on the outputs after edge N, and q_valid=1 for exactly that cycle.
- Back-to-back requests on consecutive edges produce consecutive results. q_valid stays high throughout.
- When in_valid=0 at an edge:
  - q_valid goes to 0.
  - q_left, q_right, q_carry_l, q_carry_r and op_count hold their values.
- Reset: rst_n=0 at a rising edge clears q_valid, q_left, q_right, q_carry_l, q_carry_r and op_count to 0.
- Reset has priority over an in_valid request on the same edge. That request is dropped and not counted.
- Reset does not affect l_shift or r_shift.
- There is no backpressure; every request is accepted.

## Configuration
- Macro: SHIFT_4BIT_ROTATE_EN.
- Defined: mode 10 performs a rotate as specified above.
- Undefined:
  - No rotate logic is built.
  - mode 10 behaves exactly as logical mode, including carries.
  - All other behaviour is unchanged.

## Test plan
- Combinational sweep, with results required within the same cycle:
  - a=0010: l_shift=0100, r_shift=0001.
  - a=1000: l_shift=0000, r_shift=0100.
  - a=1111: l_shift=1110, r_shift=0111.
  - a=1001: l_shift=0010, r_shift=0100.
- Reset: hold rst_n=0 for 2 edges with in_valid=1, then a=0110.
  - Registered outputs and op_count are 0; q_valid=0.
  - l_shift=1100 and r_shift=0011 throughout.
- Logical shift: in_valid=1, mode=00, amt=2, a=1011.
  - Next cycle: q_left=1100, q_right=0010, q_carry_l=0, q_carry_r=1, q_valid=1, op_count=1.
- Arithmetic right: mode=01, amt=3, a=1000.
  - Next cycle: q_right=1111, q_left=0000, q_carry_r=0, q_carry_l=0.
  - Repeat with a=0100: q_right=0000, q_carry_r=1.
- Rotate: mode=10, amt=1, a=1001.
  - With SHIFT_4BIT_ROTATE_EN: q_left=0011, q_right=1100, q_carry_l=1, q_carry_r=1.
  - Without it: q_left=0010, q_right=0100, same carries.
- Hold and wrap:
  - Issue 256 accepted requests: op_count returns to 0.
  - Then drop in_valid: all q_* values hold and q_valid=0.
